// File: rtl/rx_command_parser.sv
// Builds register-write, register-read and ALU command frames from the UART byte stream.
// Issues one-cycle execute strobes; the command fields stay held until a later frame overwrites them.
module rx_command_parser #(
  parameter int                    DATA_WIDTH             = 8,
  parameter int                    ADDRESS_WIDTH          = 4,
  parameter int                    ALU_FUNCTION_WIDTH     = 4,
  parameter logic [DATA_WIDTH-1:0] OPCODE_REG_WRITE       = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] OPCODE_REG_READ        = 8'hBB,
  parameter logic [DATA_WIDTH-1:0] OPCODE_ALU_OPERANDS    = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] OPCODE_ALU_NO_OPERANDS = 8'hDD
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         parallel_data,
  input  logic                          data_valid,
  input  logic                          parity_error,
  input  logic                          frame_error,
  input  logic                          exec_ready,
  output logic                          reg_write_enable,
  output logic                          reg_read_enable,
  output logic [ADDRESS_WIDTH-1:0]      reg_address,
  output logic [DATA_WIDTH-1:0]         reg_write_data,
  output logic                          alu_enable,
  output logic                          alu_operands_valid,
  output logic [DATA_WIDTH-1:0]         operand_A,
  output logic [DATA_WIDTH-1:0]         operand_B,
  output logic [ALU_FUNCTION_WIDTH-1:0] alu_function,
  output logic                          command_error,
  output logic                          busy
);

  // state    | meaning
  // IDLE     | waiting for an opcode byte
  // WR_ADDR  | write frame, expecting address byte
  // WR_DATA  | write frame, expecting data byte
  // RD_ADDR  | read frame, expecting address byte
  // ALU_A    | ALU frame, expecting operand A
  // ALU_B    | ALU frame, expecting operand B
  // ALU_FUNC | ALU frame, expecting function byte
  // ISSUE    | frame complete, waiting for exec_ready
  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC, ISSUE
  } state_t;

  typedef enum logic [1:0] {CMD_WR, CMD_RD, CMD_ALU} cmd_t;

  state_t                        state_q;
  cmd_t                          cmd_q;
  logic                          err_lvl_q;
  logic                          cmd_err_q;
  logic [ADDRESS_WIDTH-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]         wdata_q;
  logic [DATA_WIDTH-1:0]         opa_q;
  logic [DATA_WIDTH-1:0]         opb_q;
  logic [ALU_FUNCTION_WIDTH-1:0] func_q;
  logic                          opv_q;

  logic err_lvl_d;
  logic err_rise;
  logic fire;

  assign err_lvl_d = parity_error | frame_error;
  assign err_rise  = err_lvl_d & ~err_lvl_q;
  // Reset outranks a pending issue, so the strobes are masked in the reset cycle.
  assign fire      = (state_q == ISSUE) && exec_ready && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= CMD_WR;
      err_lvl_q <= 1'b0;
      cmd_err_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      func_q    <= '0;
      opv_q     <= 1'b0;
    end else begin
      err_lvl_q <= err_lvl_d;
      cmd_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (err_rise) begin
            cmd_err_q <= 1'b1;
          end else if (data_valid) begin
            if (parallel_data == OPCODE_REG_WRITE) begin
              state_q <= WR_ADDR;
              cmd_q   <= CMD_WR;
            end else if (parallel_data == OPCODE_REG_READ) begin
              state_q <= RD_ADDR;
              cmd_q   <= CMD_RD;
            end else if (parallel_data == OPCODE_ALU_OPERANDS) begin
              state_q <= ALU_A;
              cmd_q   <= CMD_ALU;
            end else if (parallel_data == OPCODE_ALU_NO_OPERANDS) begin
              state_q <= ALU_FUNC;
              cmd_q   <= CMD_ALU;
              opv_q   <= 1'b0;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Overrun bytes and receiver errors are reported but never drop the pending command.
          if (err_rise || data_valid) cmd_err_q <= 1'b1;
          if (exec_ready) state_q <= IDLE;
        end
        default: begin
          if (err_rise) begin
            state_q   <= IDLE;
            cmd_err_q <= 1'b1;
          end else if (data_valid) begin
            case (state_q)
              WR_ADDR: begin
                addr_q  <= parallel_data[ADDRESS_WIDTH-1:0];
                state_q <= WR_DATA;
              end
              WR_DATA: begin
                wdata_q <= parallel_data;
                state_q <= ISSUE;
              end
              RD_ADDR: begin
                addr_q  <= parallel_data[ADDRESS_WIDTH-1:0];
                state_q <= ISSUE;
              end
              ALU_A: begin
                opa_q   <= parallel_data;
                state_q <= ALU_B;
              end
              ALU_B: begin
                opb_q   <= parallel_data;
                opv_q   <= 1'b1;
                state_q <= ALU_FUNC;
              end
              ALU_FUNC: begin
                func_q  <= parallel_data[ALU_FUNCTION_WIDTH-1:0];
                state_q <= ISSUE;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign reg_write_enable   = fire && (cmd_q == CMD_WR);
  assign reg_read_enable    = fire && (cmd_q == CMD_RD);
  assign alu_enable         = fire && (cmd_q == CMD_ALU);
  assign reg_address        = addr_q;
  assign reg_write_data     = wdata_q;
  assign operand_A          = opa_q;
  assign operand_B          = opb_q;
  assign alu_function       = func_q;
  assign alu_operands_valid = opv_q;
  assign command_error      = cmd_err_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_rx_command_parser.sv
// Drives directed and random byte streams into rx_command_parser and compares every
// output each cycle against a frame-level reference model (byte queue + length table).
module tb_rx_command_parser;

  logic       clk;
  logic       reset;
  logic [7:0] parallel_data;
  logic       data_valid;
  logic       parity_error;
  logic       frame_error;
  logic       exec_ready;
  logic       reg_write_enable;
  logic       reg_read_enable;
  logic [3:0] reg_address;
  logic [7:0] reg_write_data;
  logic       alu_enable;
  logic       alu_operands_valid;
  logic [7:0] operand_A;
  logic [7:0] operand_B;
  logic [3:0] alu_function;
  logic       command_error;
  logic       busy;

  rx_command_parser dut (
    .clk(clk), .reset(reset), .parallel_data(parallel_data), .data_valid(data_valid),
    .parity_error(parity_error), .frame_error(frame_error), .exec_ready(exec_ready),
    .reg_write_enable(reg_write_enable), .reg_read_enable(reg_read_enable),
    .reg_address(reg_address), .reg_write_data(reg_write_data), .alu_enable(alu_enable),
    .alu_operands_valid(alu_operands_valid), .operand_A(operand_A), .operand_B(operand_B),
    .alu_function(alu_function), .command_error(command_error), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is the list of bytes accepted so far; its opcode fixes the length.
  logic [7:0] frame_q[$];
  bit         m_pend;
  logic [7:0] m_ptype;
  logic [3:0] m_addr;
  logic [7:0] m_wdata, m_a, m_b;
  logic [3:0] m_func;
  logic       m_opv, m_err, m_prev_lvl;

  function automatic int flen(input logic [7:0] op);
    case (op)
      8'hAA:   return 3;
      8'hBB:   return 2;
      8'hCC:   return 4;
      8'hDD:   return 2;
      default: return 0;
    endcase
  endfunction

  logic rdy_v, perr_v, ferr_v;
  int   n_we, n_re, n_alu, n_cerr;

  task automatic model_step(input logic dv, input logic [7:0] b, input logic rst);
    logic lvl, rise, nerr;
    int   idx;
    if (rst) begin
      frame_q.delete();
      m_pend = 0; m_ptype = 8'h00; m_addr = 0; m_wdata = 0; m_a = 0; m_b = 0;
      m_func = 0; m_opv = 0; m_err = 0; m_prev_lvl = 0;
      return;
    end
    lvl = perr_v | ferr_v;
    rise = lvl & ~m_prev_lvl;
    m_prev_lvl = lvl;
    nerr = 0;
    if (m_pend) begin
      if (rise || dv) nerr = 1;
      if (rdy_v) m_pend = 0;
    end else if (frame_q.size() == 0) begin
      if (rise) nerr = 1;
      else if (dv) begin
        if (flen(b) != 0) begin
          frame_q.push_back(b);
          if (b == 8'hDD) m_opv = 0;
        end else nerr = 1;
      end
    end else begin
      if (rise) begin
        frame_q.delete();
        nerr = 1;
      end else if (dv) begin
        frame_q.push_back(b);
        idx = frame_q.size() - 1;
        case (frame_q[0])
          8'hAA: if (idx == 1) m_addr = b[3:0]; else m_wdata = b;
          8'hBB: m_addr = b[3:0];
          8'hCC: if (idx == 1) m_a = b; else if (idx == 2) begin m_b = b; m_opv = 1; end
                 else m_func = b[3:0];
          default: m_func = b[3:0];
        endcase
        if (frame_q.size() == flen(frame_q[0])) begin
          m_pend = 1;
          m_ptype = frame_q[0];
          frame_q.delete();
        end
      end
    end
    m_err = nerr;
  endtask

  task automatic check_outputs(input logic rst);
    logic fire;
    fire = m_pend && rdy_v && !rst;
    chk("reg_write_enable", reg_write_enable, fire && m_ptype == 8'hAA);
    chk("reg_read_enable",  reg_read_enable,  fire && m_ptype == 8'hBB);
    chk("alu_enable",       alu_enable,       fire && (m_ptype == 8'hCC || m_ptype == 8'hDD));
    chk("busy",             busy,             m_pend || frame_q.size() != 0);
    chk("command_error",    command_error,    m_err);
    chk("reg_address",      reg_address,      m_addr);
    chk("reg_write_data",   reg_write_data,   m_wdata);
    chk("operand_A",        operand_A,        m_a);
    chk("operand_B",        operand_B,        m_b);
    chk("alu_function",     alu_function,     m_func);
    chk("alu_operands_valid", alu_operands_valid, m_opv);
    n_we   += reg_write_enable;
    n_re   += reg_read_enable;
    n_alu  += alu_enable;
    n_cerr += command_error;
  endtask

  task automatic step(input logic dv, input logic [7:0] b, input logic rst);
    data_valid = dv; parallel_data = b; reset = rst;
    exec_ready = rdy_v; parity_error = perr_v; frame_error = ferr_v;
    #1;
    check_outputs(rst);
    @(posedge clk);
    model_step(dv, b, rst);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic clr_counts();
    n_we = 0; n_re = 0; n_alu = 0; n_cerr = 0;
  endtask

  initial begin
    rdy_v = 1; perr_v = 0; ferr_v = 0;
    reset = 1; data_valid = 0; parallel_data = 0;
    exec_ready = 1; parity_error = 0; frame_error = 0;
    clr_counts();
    @(posedge clk);
    model_step(1'b0, 8'h00, 1'b1);
    @(negedge clk);

    // 1: register write
    clr_counts();
    send(8'hAA); send(8'h05); send(8'h3C); idle(3);
    chk("s1_we_count", n_we, 1);
    chk("s1_addr", reg_address, 4'h5);
    chk("s1_wdata", reg_write_data, 8'h3C);

    // 2: register read, address upper bits dropped
    clr_counts();
    send(8'hBB); send(8'h1F); idle(3);
    chk("s2_re_count", n_re, 1);
    chk("s2_other_strobes", n_we + n_alu, 0);
    chk("s2_addr", reg_address, 4'hF);

    // 3: ALU with operands, delayed exec_ready and an overrun byte
    clr_counts();
    rdy_v = 0;
    send(8'hCC); send(8'h12); send(8'h34); send(8'h07);
    idle(2); send(8'h55); idle(2);
    chk("s3_no_strobe_while_wait", n_alu, 0);
    rdy_v = 1;
    idle(3);
    chk("s3_alu_count", n_alu, 1);
    chk("s3_cerr_count", n_cerr, 1);
    chk("s3_opa", operand_A, 8'h12);
    chk("s3_opb", operand_B, 8'h34);
    chk("s3_func", alu_function, 4'h7);
    chk("s3_opv", alu_operands_valid, 1'b1);

    // 4: ALU without operands
    clr_counts();
    send(8'hDD); send(8'h02); idle(3);
    chk("s4_alu_count", n_alu, 1);
    chk("s4_func", alu_function, 4'h2);
    chk("s4_opv", alu_operands_valid, 1'b0);
    chk("s4_opa_held", operand_A, 8'h12);

    // 5: frame error mid-frame aborts the write
    clr_counts();
    send(8'hAA); send(8'h05);
    ferr_v = 1; idle(3); ferr_v = 0; idle(2);
    chk("s5_cerr_count", n_cerr, 1);
    chk("s5_no_write", n_we, 0);
    chk("s5_idle", busy, 1'b0);
    send(8'hBB); send(8'h03); idle(3);
    chk("s5_re_count", n_re, 1);
    chk("s5_addr", reg_address, 4'h3);

    // 6: unknown opcode, then reset in mid-frame
    clr_counts();
    send(8'h77); idle(2);
    chk("s6_cerr_unknown", n_cerr, 1);
    send(8'hAA); send(8'h05);
    step(1'b0, 8'h00, 1'b1);
    chk("s6_busy_after_reset", busy, 1'b0);
    chk("s6_addr_after_reset", reg_address, 4'h0);
    clr_counts();
    send(8'h11); idle(2);
    chk("s6_cerr_after_reset", n_cerr, 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] b;
      logic dv, rst;
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 3))
          0: b = 8'hAA;
          1: b = 8'hBB;
          2: b = 8'hCC;
          default: b = 8'hDD;
        endcase
      end else b = 8'($urandom);
      dv    = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 249) == 0);
      rdy_v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) perr_v = ~perr_v;
      if ($urandom_range(0, 79) == 0) ferr_v = ~ferr_v;
      step(dv, b, rst);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
